// File: rtl/mem_store_buffer_if.sv
// Bus bundle for the posted-write store buffer: CPU request side, data-memory
// drive side, and FIFO status.
interface mem_store_buffer_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              cpu_mem_read;
  logic              cpu_mem_write;
  logic [1:0]        cpu_load_mode;
  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] cpu_write_data;

  logic              stall;
  logic              dmem_mem_read;
  logic              dmem_mem_write;
  logic [1:0]        dmem_load_mode;
  logic [ADDR_W-1:0] dmem_address;
  logic [DATA_W-1:0] dmem_write_data;

  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  modport master (
    output cpu_mem_read, cpu_mem_write, cpu_load_mode, cpu_address, cpu_write_data,
    input  stall, dmem_mem_read, dmem_mem_write, dmem_load_mode, dmem_address,
           dmem_write_data, count, full, empty
  );

  modport slave (
    input  cpu_mem_read, cpu_mem_write, cpu_load_mode, cpu_address, cpu_write_data,
    output stall, dmem_mem_read, dmem_mem_write, dmem_load_mode, dmem_address,
           dmem_write_data, count, full, empty
  );
endinterface

// File: rtl/mem_store_buffer.sv
// Posted-write store buffer: stores queue in a FIFO and drain when loads leave
// the memory port free; loads bypass unless they overlap a queued store.
module mem_store_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  mem_store_buffer_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;

  logic              full, empty;
  logic              hazard, ld_go, drain, enq;
  logic [ADDR_W-1:0] ld_len;
  logic [PTR_W-1:0]  offset;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Hazard uses modular distance so address wrap at 2^ADDR_W counts as adjacent.
  always_comb begin
    hazard = 1'b0;
    offset = '0;
    ld_len = (bus.cpu_load_mode == 2'b00) ? ADDR_W'(4) : ADDR_W'(2);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - head_q;
      if ((CNT_W'(offset) < count_q) &&
          (((bus.cpu_address - addr_q[i]) < ADDR_W'(4)) ||
           ((addr_q[i] - bus.cpu_address) < ld_len)))
        hazard = 1'b1;
    end
    hazard = hazard && bus.cpu_mem_read;
  end

  always_comb begin
    ld_go = !reset && bus.cpu_mem_read && !hazard;
    drain = !reset && !empty && !ld_go;
    enq   = !reset && bus.cpu_mem_write && !bus.cpu_mem_read && !full;

    bus.stall           = !reset && ((bus.cpu_mem_read && hazard) ||
                                     (bus.cpu_mem_write && !bus.cpu_mem_read && full));
    bus.dmem_mem_read   = ld_go;
    bus.dmem_mem_write  = drain;
    bus.dmem_load_mode  = bus.cpu_load_mode;
    bus.dmem_address    = ld_go ? bus.cpu_address : addr_q[head_q];
    bus.dmem_write_data = data_q[head_q];
    bus.count           = count_q;
    bus.full            = full;
    bus.empty           = empty;
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= bus.cpu_address;
      data_q[tail_q] <= bus.cpu_write_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq)   tail_q <= tail_q + PTR_W'(1);
      if (drain) head_q <= head_q + PTR_W'(1);
      unique case ({enq, drain})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_store_buffer.sv
// Scoreboard bench for mem_store_buffer: a byte-level queue model predicts each
// cycle's memory-port activity; a negedge monitor compares the DUT against it.
module tb_mem_store_buffer;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_store_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  mem_store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } st_t;

  typedef struct {
    bit          stall;
    bit          rd_go;
    bit          wr_go;
    int          cnt;
    logic [31:0] addr;
    logic [1:0]  mode;
  } cyc_t;

  st_t  model_q[$];
  st_t  exp_wr[$];
  cyc_t exp_cyc[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte-set intersection, with 32-bit wraparound arithmetic.
  function automatic bit overlaps(input logic [31:0] ld, input int len, input logic [31:0] st);
    logic [31:0] lb, sb;
    for (int b = 0; b < len; b++)
      for (int s = 0; s < 4; s++) begin
        lb = ld + 32'(b);
        sb = st + 32'(s);
        if (lb == sb) return 1'b1;
      end
    return 1'b0;
  endfunction

  task automatic step(input bit rst, input bit rd, input bit wr, input logic [1:0] mode,
                      input logic [31:0] a, input logic [31:0] d, output bit stalled);
    cyc_t e;
    bit   haz, full_m;
    @(posedge clk);
    #1;
    reset              = rst;
    bus.cpu_mem_read   = rd;
    bus.cpu_mem_write  = wr;
    bus.cpu_load_mode  = mode;
    bus.cpu_address    = a;
    bus.cpu_write_data = d;
    e.addr = a;
    e.mode = mode;
    if (rst) begin
      model_q.delete();
      e.stall = 0; e.rd_go = 0; e.wr_go = 0; e.cnt = 0;
    end else begin
      full_m = (model_q.size() == DEPTH);
      haz = 1'b0;
      if (rd)
        foreach (model_q[i])
          if (overlaps(a, (mode == 2'b00) ? 4 : 2, model_q[i].addr)) haz = 1'b1;
      e.cnt   = model_q.size();
      e.stall = (rd && haz) || (wr && !rd && full_m);
      e.rd_go = rd && !haz;
      e.wr_go = (model_q.size() > 0) && !e.rd_go;
      if (e.wr_go) exp_wr.push_back(model_q.pop_front());
      if (wr && !rd && !full_m) model_q.push_back('{addr: a, data: d});
    end
    exp_cyc.push_back(e);
    stalled = e.stall;
  endtask

  // Issue a request, holding it while stalled (bounded retries).
  task automatic req(input bit rd, input bit wr, input logic [1:0] mode,
                     input logic [31:0] a, input logic [31:0] d);
    bit st;
    int tries = 0;
    do begin
      step(1'b0, rd, wr, mode, a, d, st);
      tries++;
    end while (st && tries < 20);
    if (st) chk("retry_bound", 64'(tries), 64'(0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) req(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  always @(negedge clk) begin
    cyc_t e;
    st_t  w;
    if (exp_cyc.size() > 0) begin
      e = exp_cyc.pop_front();
      chk("stall", 64'(bus.stall), 64'(e.stall));
      chk("dmem_mem_read", 64'(bus.dmem_mem_read), 64'(e.rd_go));
      chk("dmem_mem_write", 64'(bus.dmem_mem_write), 64'(e.wr_go));
      chk("count", 64'(bus.count), 64'(e.cnt));
      chk("empty", 64'(bus.empty), 64'(e.cnt == 0));
      chk("full", 64'(bus.full), 64'(e.cnt == DEPTH));
      if (e.rd_go) begin
        chk("load_addr", 64'(bus.dmem_address), 64'(e.addr));
        chk("load_mode", 64'(bus.dmem_load_mode), 64'(e.mode));
      end
      if (bus.dmem_mem_write) begin
        if (exp_wr.size() == 0) chk("unexpected_write", 64'(bus.dmem_address), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          w = exp_wr.pop_front();
          chk("drain_addr", 64'(bus.dmem_address), 64'(w.addr));
          chk("drain_data", 64'(bus.dmem_write_data), 64'(w.data));
        end
      end
    end
  end

  initial begin
    bit          st;
    int          op;
    logic [31:0] a;
    bus.cpu_mem_read = 0; bus.cpu_mem_write = 0; bus.cpu_load_mode = 0;
    bus.cpu_address = 0; bus.cpu_write_data = 0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, st);
    step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, st);

    // Single store then idle drain
    req(1'b0, 1'b1, 2'b00, 32'h100, 32'hDEADBEEF);
    idle(2);

    // Stores interleaved with port-holding loads, then a 5th store and drains
    req(1'b0, 1'b1, 2'b00, 32'h0, 32'h1111_0000);
    req(1'b1, 1'b0, 2'b00, 32'h800, 32'h0);
    req(1'b0, 1'b1, 2'b00, 32'h4, 32'h1111_0004);
    req(1'b1, 1'b0, 2'b00, 32'h800, 32'h0);
    req(1'b0, 1'b1, 2'b00, 32'h8, 32'h1111_0008);
    req(1'b1, 1'b0, 2'b00, 32'h800, 32'h0);
    req(1'b0, 1'b1, 2'b00, 32'hC, 32'h1111_000C);
    req(1'b0, 1'b1, 2'b00, 32'h10, 32'h1111_0010);
    idle(5);

    // Overlapping half load stalls, then a word load next door does not
    req(1'b0, 1'b1, 2'b00, 32'h200, 32'hA5A5_0200);
    req(1'b1, 1'b0, 2'b01, 32'h202, 32'h0);
    req(1'b0, 1'b1, 2'b00, 32'h200, 32'hA5A5_0201);
    req(1'b1, 1'b0, 2'b00, 32'h204, 32'h0);
    idle(2);

    // Wraparound overlap
    req(1'b0, 1'b1, 2'b00, 32'hFFFF_FFFE, 32'hCAFE_F00D);
    req(1'b1, 1'b0, 2'b00, 32'h0000_0000, 32'h0);
    req(1'b0, 1'b1, 2'b00, 32'hFFFF_FFFE, 32'hCAFE_F00E);
    req(1'b1, 1'b0, 2'b10, 32'hFFFF_FFFC, 32'h0);
    idle(2);

    // Simultaneous enqueue and drain, walking the pointers around
    for (int i = 0; i < 2 * DEPTH + 1; i++)
      req(1'b0, 1'b1, 2'b00, 32'h300 + 32'(4 * i), 32'hB000_0000 + 32'(i));
    idle(2);

    // Reset mid-run with queued stores
    req(1'b0, 1'b1, 2'b00, 32'h40, 32'h4040_4040);
    req(1'b1, 1'b0, 2'b00, 32'h900, 32'h0);
    step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, st);
    step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, st);
    exp_wr.delete();
    idle(2);

    // Randomised traffic over a small address window and near the wrap point
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 9);
      a  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 15)))
                                       : 32'($urandom_range(0, 47));
      if (op < 2)      idle(1);
      else if (op < 6) req(1'b1, 1'b0, 2'($urandom_range(0, 2)), a, 32'h0);
      else             req(1'b0, 1'b1, 2'b00, a, $urandom);
    end
    idle(DEPTH + 2);

    @(posedge clk);
    #1;
    chk("pending_writes", 64'(exp_wr.size()), 64'(0));
    chk("pending_cycles", 64'(exp_cyc.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
